writeback_queue: RTL

- Collects completed results from exec pipes A and B, buffers them in an in-order FIFO, and drains up to two per cycle into the register controller's writeback ports.
- Its outputs drive the register controller's writeback inputs: the write-enable flags, write addresses, write values and operation status for each port.
- Decouples exec completion from register-file write timing.
- Applies backpressure to exec when nearly full.

---
 rtl/wbq_pkg.sv | 20 ++
 rtl/wbq_fifo2.sv | 68 ++++++
 rtl/writeback_queue.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wbq_pkg.sv
// wbq_pkg: types and constants shared by the writeback queue and the
// register controller it feeds.
//   WBQ_ADDR_W / WBQ_DATA_W : default register address / data widths
//   STATUS_OVF / STATUS_UNF : bit positions inside the 2-bit status field
//   wbqEntry_t              : one queued result {addr, value, status}
package wbq_pkg;

    localparam int WBQ_ADDR_W = 5;
    localparam int WBQ_DATA_W = 16;

    localparam int STATUS_OVF = 1;
    localparam int STATUS_UNF = 0;

    typedef struct packed {
        logic [WBQ_ADDR_W-1:0]        addr;
        logic [WBQ_DATA_W-1:0]        value;
        logic [STATUS_OVF:STATUS_UNF] status;
    } wbqEntry_t;

endpackage

// File: rtl/wbq_fifo2.sv
// wbq_fifo2: circular buffer accepting up to two writes and retiring up to
// two reads per cycle.
//   clock_i, reset_i       : clock, asynchronous active-low reset
//   pushCnt                : number of entries written this cycle (0..2);
//                            pushData0 goes to wptr, pushData1 to wptr+1
//   popCnt                 : number of entries retired this cycle (0..2)
//   head0, head1           : oldest and second-oldest entries (unregistered)
//   count                  : current occupancy
// The caller guarantees pushCnt never exceeds the free space (counting the
// slots vacated by this cycle's pops) and popCnt never exceeds count.
module wbq_fifo2
    import wbq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 23
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [1:0]             pushCnt,
    input  logic [W-1:0]           pushData0,
    input  logic [W-1:0]           pushData1,
    input  logic [1:0]             popCnt,
    output logic [W-1:0]           head0,
    output logic [W-1:0]           head1,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptrReg;
    logic [PW-1:0] rptrReg;
    logic [PW:0]   countReg;
    logic [PW-1:0] wptrPlus1;
    logic [PW-1:0] rptrPlus1;

    // DEPTH is a power of two, so pointer arithmetic wraps on its own.
    assign wptrPlus1 = wptrReg + PW'(1);
    assign rptrPlus1 = rptrReg + PW'(1);

    // Reads see the array contents from before this edge, so a pop of a slot
    // that is rewritten in the same cycle (queue full) still gets the old entry.
    assign head0 = mem[rptrReg];
    assign head1 = mem[rptrPlus1];
    assign count = countReg;

    always_ff @(posedge clock_i) begin
        if (pushCnt != 2'd0) begin
            mem[wptrReg] <= pushData0;
        end
        if (pushCnt == 2'd2) begin
            mem[wptrPlus1] <= pushData1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wptrReg  <= '0;
            rptrReg  <= '0;
            countReg <= '0;
        end else begin
            wptrReg  <= wptrReg + PW'(pushCnt);
            rptrReg  <= rptrReg + PW'(popCnt);
            countReg <= countReg + (PW+1)'(pushCnt) - (PW+1)'(popCnt);
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: buffers completed results from exec pipes A and B in an
// in-order FIFO and drains up to two per cycle into the register
// controller's writeback ports.
//   clock_i, reset_i                 : clock, asynchronous active-low reset
//   resValidX_i/resAddrX_i/resValX_i/resStatusX_i : pipe X result (X = A, B)
//   stall_o                          : exec must not present results next cycle
//   overflow_o                       : sticky, a result was dropped
//   wbX_o/wbAddrX_o/wbValX_o/operationStatusX_o   : writeback port X
//   count_o                          : FIFO occupancy
// Build option WBQ_BYPASS_EN: when the FIFO is empty, incoming results load
// straight into the output registers (1-cycle latency instead of 2).
module writeback_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = WBQ_ADDR_W,
    parameter int DATA_W = WBQ_DATA_W
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   resValidA_i,
    input  logic [ADDR_W-1:0]      resAddrA_i,
    input  logic [DATA_W-1:0]      resValA_i,
    input  logic [1:0]             resStatusA_i,
    input  logic                   resValidB_i,
    input  logic [ADDR_W-1:0]      resAddrB_i,
    input  logic [DATA_W-1:0]      resValB_i,
    input  logic [1:0]             resStatusB_i,
    output logic                   stall_o,
    output logic                   overflow_o,
    output logic                   wbA_o,
    output logic                   wbB_o,
    output logic [ADDR_W-1:0]      wbAddrA_o,
    output logic [ADDR_W-1:0]      wbAddrB_o,
    output logic [DATA_W-1:0]      wbValA_o,
    output logic [DATA_W-1:0]      wbValB_o,
    output logic [1:0]             operationStatusA_o,
    output logic [1:0]             operationStatusB_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Same layout as wbqEntry_t, but following this instance's widths.
    typedef struct packed {
        logic [ADDR_W-1:0]            addr;
        logic [DATA_W-1:0]            value;
        logic [STATUS_OVF:STATUS_UNF] status;
    } entry_t;

    localparam int EW = $bits(entry_t);

    entry_t        entA, entB;
    entry_t        head0, head1;
    entry_t        pushData0, pushData1;
    entry_t        loadDataA, loadDataB;
    logic          enqA, enqB;
    logic          loadA, loadB;
    logic          dropped;
    logic [1:0]    popCnt, reqCnt, acceptCnt;
    logic [CW-1:0] count;
    logic [CW:0]   room, countNext;
    logic          stallReg, overflowReg;

    assign entA = {resAddrA_i, resValA_i, resStatusA_i};
    assign entB = {resAddrB_i, resValB_i, resStatusB_i};

    wbq_fifo2 #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) fifo (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .pushCnt   (acceptCnt),
        .pushData0 (pushData0),
        .pushData1 (pushData1),
        .popCnt    (popCnt),
        .head0     (head0),
        .head1     (head1),
        .count     (count)
    );

    // Two heads with the same destination must not write in the same cycle,
    // so only the older one leaves; the younger becomes the head next cycle.
    always_comb begin
        popCnt = 2'd0;
        if (count == CW'(1)) begin
            popCnt = 2'd1;
        end else if (count > CW'(1)) begin
            popCnt = (head0.addr == head1.addr) ? 2'd1 : 2'd2;
        end
    end

    always_comb begin
        loadA     = (popCnt != 2'd0);
        loadB     = (popCnt == 2'd2);
        loadDataA = head0;
        loadDataB = head1;
        enqA      = resValidA_i;
        enqB      = resValidB_i;
`ifdef WBQ_BYPASS_EN
        // An empty FIFO means nothing older is waiting, so results can skip
        // the buffer without reordering. A same-address B still queues so it
        // lands one cycle after A.
        if (count == '0) begin
            if (resValidA_i) begin
                loadA     = 1'b1;
                loadDataA = entA;
                enqA      = 1'b0;
                if (resValidB_i && (resAddrB_i != resAddrA_i)) begin
                    loadB     = 1'b1;
                    loadDataB = entB;
                    enqB      = 1'b0;
                end
            end else if (resValidB_i) begin
                loadA     = 1'b1;
                loadDataA = entB;
                enqB      = 1'b0;
            end
        end
`endif
        // Compact the pushes so the oldest accepted result sits at wptr.
        reqCnt    = {1'b0, enqA} + {1'b0, enqB};
        pushData0 = enqA ? entA : entB;
        pushData1 = entB;

        // Slots vacated by this cycle's pops are reusable by this cycle's
        // pushes; whatever does not fit is dropped, youngest first.
        room      = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(popCnt);
        dropped   = ((CW+1)'(reqCnt) > room);
        acceptCnt = dropped ? room[1:0] : reqCnt;
        countNext = {1'b0, count} + (CW+1)'(acceptCnt) - (CW+1)'(popCnt);
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wbA_o              <= 1'b0;
            wbB_o              <= 1'b0;
            wbAddrA_o          <= '0;
            wbAddrB_o          <= '0;
            wbValA_o           <= '0;
            wbValB_o           <= '0;
            operationStatusA_o <= '0;
            operationStatusB_o <= '0;
            stallReg           <= 1'b0;
            overflowReg        <= 1'b0;
        end else begin
            wbA_o              <= loadA;
            wbB_o              <= loadB;
            wbAddrA_o          <= loadA ? loadDataA.addr   : '0;
            wbAddrB_o          <= loadB ? loadDataB.addr   : '0;
            wbValA_o           <= loadA ? loadDataA.value  : '0;
            wbValB_o           <= loadB ? loadDataB.value  : '0;
            operationStatusA_o <= loadA ? loadDataA.status : '0;
            operationStatusB_o <= loadB ? loadDataB.status : '0;
            // Raised while fewer than two slots remain, so the two results
            // exec may already have in flight still fit.
            stallReg           <= (countNext > (CW+1)'(DEPTH - 2));
            overflowReg        <= overflowReg | dropped;
        end
    end

    assign stall_o    = stallReg;
    assign overflow_o = overflowReg;
    assign count_o    = count;

endmodule
